// File: rtl/demux7_capture.sv
// Demultiplexing capture register: routes a serial bit into one of seven
// positions, by addressed write or by an automatic 0..6 sequential capture.
module demux7_capture (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       DataIn,
  input  logic [2:0] Select,
  input  logic       WriteEn,
  input  logic       Start,
  input  logic       DataValid,
  output logic [0:6] Out,
  output logic       Busy,
  output logic       Done,
  output logic       Error
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [0:6] out_q, out_d;
  logic       error_q, error_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    out_d   = out_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        // Start takes priority and discards a coincident write entirely.
        if (Start) begin
          state_d = ST_SHIFT;
          count_d = '0;
          out_d   = '0;
          error_d = 1'b0;
        end else if (WriteEn) begin
          if (Select != 3'd7) begin
            out_d[Select] = DataIn;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (DataValid) begin
          out_d[count_q] = DataIn;
          if (count_q == 3'd6) begin
            count_d = '0;
            state_d = ST_DONE;
          end else begin
            count_d = count_q + 3'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      out_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      out_q   <= out_d;
      error_q <= error_d;
    end
  end

  assign Out   = out_q;
  assign Busy  = (state_q == ST_SHIFT);
  assign Done  = (state_q == ST_DONE);
  assign Error = error_q;

endmodule

// File: tb/tb_demux7_capture.sv
// Directed and randomized bench for demux7_capture against a cycle-level
// reference model tracking the next capture position.
module tb_demux7_capture;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       DataIn = 1'b0;
  logic [2:0] Select = 3'd0;
  logic       WriteEn = 1'b0;
  logic       Start = 1'b0;
  logic       DataValid = 1'b0;
  logic [0:6] Out;
  logic       Busy, Done, Error;

  int tests = 0;
  int fails = 0;

  // pos = -1: idle; 0..6: next position to capture; 7: done cycle
  int         pos = -1;
  logic [0:6] mout = '0;
  logic       merr = 1'b0;

  demux7_capture dut (
    .Clock(Clock), .Reset(Reset), .DataIn(DataIn), .Select(Select),
    .WriteEn(WriteEn), .Start(Start), .DataValid(DataValid),
    .Out(Out), .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic d, input logic [2:0] sel,
                      input logic we, input logic st, input logic dv);
    Reset = r; DataIn = d; Select = sel; WriteEn = we; Start = st; DataValid = dv;
    @(posedge Clock);
    if (r) begin
      pos = -1; mout = '0; merr = 1'b0;
    end else if (pos < 0) begin
      if (st) begin
        pos = 0; mout = '0; merr = 1'b0;
      end else if (we) begin
        if (sel < 3'd7) mout[sel] = d;
        else merr = 1'b1;
      end
    end else if (pos <= 6) begin
      if (dv) begin
        mout[pos] = d;
        pos++;
      end
    end else begin
      pos = -1;
    end
    #1;
    chk7("out", Out, mout);
    chk1("busy", Busy, (pos >= 0 && pos <= 6));
    chk1("done", Done, (pos == 7));
    chk1("error", Error, merr);
    chk1("busy_done_excl", Busy & Done, 1'b0);
  endtask

  initial begin
    logic [6:0] word;
    int n;
    int busy_cnt;
    int done_cnt;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk7("reset_out", Out, 7'b0000000);

    // addressed write position 2
    step(0, 1, 3'd2, 1, 0, 0);
    chk7("wr2_out", Out, 7'b0010000);
    chk1("wr2_err", Error, 1'b0);

    // illegal select sets sticky error
    step(0, 1, 3'd7, 1, 0, 0);
    chk7("sel7_out", Out, 7'b0010000);
    chk1("sel7_err", Error, 1'b1);
    step(0, 1, 3'd5, 1, 0, 0);
    step(0, 1, 3'd0, 1, 0, 0);
    chk1("err_sticky", Error, 1'b1);
    chk7("wr_after_err", Out, 7'b1010010);

    // Start with coincident write: start wins
    step(0, 1, 3'd0, 1, 1, 0);
    chk1("start_out0", Out[0], 1'b0);
    chk1("start_err_clr", Error, 1'b0);
    busy_cnt = Busy ? 1 : 0;
    done_cnt = 0;
    word = 7'b1011001;
    for (int i = 0; i < 7; i++) begin
      step(0, word[6-i], 3'($urandom_range(0, 7)), 1, 1, 1);
      if (Busy) busy_cnt++;
      if (Done) done_cnt++;
    end
    chk7("seq_word", Out, 7'b1011001);
    step(0, 0, 3'd0, 1, 1, 0);
    if (Done) done_cnt++;
    chk7("done_we_hold", Out, 7'b1011001);
    chkn("seq_busy_cycles", busy_cnt, 7);
    chkn("seq_done_cycles", done_cnt, 1);
    step(0, 0, 3'd0, 0, 0, 0);

    // gap of three invalid cycles after bit 2 delays Done by three
    step(0, 0, 3'd0, 0, 1, 0);
    n = 0;
    for (int i = 0; i < 20 && !Done; i++) begin
      step(0, 1'($urandom), 3'd0, 0, 0, (i >= 2 && i < 5) ? 1'b0 : 1'b1);
      n++;
    end
    chkn("gap_done_latency", n, 10);
    step(0, 0, 3'd0, 0, 0, 0);

    // reset mid-capture discards the word
    step(0, 0, 3'd0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 3'd0, 0, 0, 1);
    step(1, 1, 3'd0, 0, 0, 1);
    chk7("midrst_out", Out, 7'b0000000);
    chk1("midrst_busy", Busy, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 3'd0, 0, 0, 1);
      if (Done) done_cnt++;
    end
    chkn("midrst_no_done", done_cnt, 0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), 3'($urandom),
           1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux7_capture.md
# demux7_capture

Demultiplexing capture register, the write-side counterpart of the 7:1 bit-select mux: a single serial bit is routed into one of seven output positions. Positions are set either by direct addressed writes (`Select` picks the position) or by an automatic sequential capture that fills positions 0..6 in order and then pulses `Done`. It sits between a serial or switch-driven bit source and any logic that consumes a 7-bit parallel word.

## Interface
- Parameters: none (word width fixed at 7, select width fixed at 3).
- `Clock`  in  1  rising-edge clock for all state.
- `Reset`  in  1  synchronous, active-high; sampled on the `Clock` rising edge.
- `DataIn`  in  1  bit to be written.
- `Select`  in  3  target position for addressed writes; valid codes are 3'b000..3'b110.
- `WriteEn`  in  1  addressed-write strobe; honoured only in IDLE.
- `Start`  in  1  begins a sequential capture; honoured only in IDLE.
- `DataValid`  in  1  qualifies `DataIn` during sequential capture.
- `Out`  out  [0:6]  captured word; `Out[0]` is position 0, which is also the first bit captured sequentially.
- `Busy`  out  1  high while in SHIFT.
- `Done`  out  1  one-cycle pulse after the 7th sequential bit is captured.
- `Error`  out  1  sticky flag: an addressed write was attempted with `Select` = 3'b111.

## Operation
- State machine states: IDLE, SHIFT, DONE. Internal 3-bit position counter `count`.
- IDLE:
  - `Start`=1: go to SHIFT, clear `Out` to 7'b0, set `count` to 0, clear `Error`.
  - Otherwise, `WriteEn`=1 with `Select` in 0..6: `Out[Select]` <= `DataIn`. All other bits are held.
  - `WriteEn`=1 with `Select`=7: `Out` is unchanged and `Error` is set to 1.
  - `Start` and `WriteEn` asserted together: `Start` wins and the write is discarded, including any `Error` it would have set.
- SHIFT:
  - On each edge with `DataValid`=1: `Out[count]` <= `DataIn` and `count` increments.
  - `DataValid`=0: all state is held, and there is no timeout.
  - The edge that captures position 6 moves the FSM to DONE, and `count` returns to 0. There is no wrap past 6.
  - `WriteEn` and `Start` are ignored, and `Select` is a don't-care.
- DONE: lasts exactly one cycle, then goes to IDLE. `Start` and `WriteEn` are ignored in this cycle.
- `Error` clears only on `Reset` or on an accepted `Start`.

## Timing
- Reset values on the edge where `Reset`=1: state=IDLE, `count`=0, `Out`=7'b0000000, `Busy`=0, `Done`=0, `Error`=0.
- `Reset` has priority over every other input, including mid-SHIFT. A partial word is discarded and `Done` does not fire.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Addressed write latency: `Out` reflects the write in the cycle after the `WriteEn` edge.
- Sequential capture:
  - `Start` sampled at edge k puts the FSM in SHIFT, so `Busy`=1 from cycle k+1.
  - With `DataValid` held high, bits are captured on edges k+1..k+7.
  - DONE holds in cycle k+8: `Busy`=0, `Done`=1, and `Out` holds the full word.
  - IDLE resumes in cycle k+9.
- `Busy` and `Done` are never high in the same cycle.

## Test plan
- Reset, then `WriteEn`=1, `Select`=3'b010, `DataIn`=1 -> next cycle `Out`=7'b0010000 (`Out[2]`=1), `Error`=0.
- Addressed write with `Select`=3'b111, `DataIn`=1 -> `Out` unchanged and `Error`=1. The flag stays 1 across later valid writes until `Start` or `Reset`.
- `Start`, then `DataValid`=1 for 7 cycles with `DataIn` sequence 1,0,1,1,0,0,1 -> `Out`=[0:6]=1011001, `Busy` high for 7 cycles, then `Done` high for exactly 1 cycle.
- Sequential capture with `DataValid` low for 3 cycles after bit 2 -> `Out` and `count` are held, and `Done` arrives 3 cycles later than in the gap-free case.
- `Reset` asserted after 4 sequential bits -> next cycle all outputs are 0, and `Done` never pulses.
- `Start` and `WriteEn` (`Select`=0, `DataIn`=1) asserted together in IDLE -> capture starts and `Out[0]`=0. `WriteEn` pulses during SHIFT and DONE leave `Out` unaffected.
